// File: rtl/float_pkg.sv
// Shared single-precision float constants and the accumulator FSM encoding.
package float_pkg;
  localparam int EXP_BIAS = 127;
  localparam int EXP_W    = 8;
  localparam int FRAC_W   = 23;
  localparam int MANT_W   = 24;

  localparam logic [EXP_W-1:0] EXP_INF = 8'hFF;
  localparam logic [31:0]      POS_INF = 32'h7F80_0000;

  typedef enum logic [1:0] {IDLE, ALIGN, ADD, NORM} state_t;

  // What NORM does with the in-flight operand, decided once in ALIGN.
  typedef enum logic [1:0] {MODE_ADD, MODE_COPY, MODE_KEEP} mode_t;
endpackage

// File: rtl/float_unpack.sv
// Splits an IEEE-754 single into fields with the hidden bit restored.
module float_unpack
  import float_pkg::*;
(
  input  logic [31:0]       val,
  output logic              sign,
  output logic [EXP_W-1:0]  exp,
  output logic [MANT_W-1:0] mant,
  output logic              is_zero,
  output logic              is_special
);
  assign sign       = val[31];
  assign exp        = val[30:FRAC_W];
  assign mant       = {1'b1, val[FRAC_W-1:0]};
  assign is_zero    = (exp == '0);
  assign is_special = (exp == EXP_INF);
endmodule

// File: rtl/float_accumulator.sv
// Running float sum of non-negative singles; fixed 4-cycle accept-to-result FSM,
// truncating rounding, saturates to +Inf with a sticky overflow flag.
module float_accumulator
  import float_pkg::*;
#(
  parameter logic [31:0] ACC_INIT = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  output logic [31:0] acc,
  output logic        acc_valid,
  output logic        err,
  output logic        ovf
);
  state_t             state_q, state_d;
  mode_t              mode_q, mode_d;
  logic [31:0]        op_q, op_sel;
  logic [EXP_W-1:0]   exp_q;
  logic [MANT_W-1:0]  ma_q, mb_q;
  logic [MANT_W:0]    sum_q;

  logic               op_sign, op_zero, op_special;
  logic [EXP_W-1:0]   op_exp;
  logic [MANT_W-1:0]  op_mant;
  logic               acc_sign, acc_zero, acc_special;
  logic [EXP_W-1:0]   acc_exp;
  logic [MANT_W-1:0]  acc_mant;

  // Classify in_data while idle, then look at the held operand during ALIGN.
  assign op_sel = (state_q == IDLE) ? in_data : op_q;

  float_unpack u_op (
    .val(op_sel), .sign(op_sign), .exp(op_exp), .mant(op_mant),
    .is_zero(op_zero), .is_special(op_special)
  );

  float_unpack u_acc (
    .val(acc), .sign(acc_sign), .exp(acc_exp), .mant(acc_mant),
    .is_zero(acc_zero), .is_special(acc_special)
  );

  logic accept, reject;
  assign in_ready = (state_q == IDLE) & ~clr & ~rst;
  assign accept   = in_valid & in_ready;
  assign reject   = op_sign | op_special;

  // Alignment: larger exponent is the reference, the other mantissa shifts right.
  logic               acc_ge;
  logic [EXP_W-1:0]   diff, big_exp;
  logic [MANT_W-1:0]  big_mant, small_mant, small_sh;

  always_comb begin
    acc_ge     = (acc_exp >= op_exp);
    diff       = acc_ge ? (acc_exp - op_exp) : (op_exp - acc_exp);
    big_exp    = acc_ge ? acc_exp  : op_exp;
    big_mant   = acc_ge ? acc_mant : op_mant;
    small_mant = acc_ge ? op_mant  : acc_mant;
    small_sh   = (diff >= EXP_W'(MANT_W)) ? '0 : (small_mant >> diff);
    if (op_zero || acc_special || acc_sign) mode_d = MODE_KEEP;
    else if (acc_zero)                      mode_d = MODE_COPY;
    else                                    mode_d = MODE_ADD;
  end

  // Normalize: the sum is never below 1.0, so at most a single right shift.
  logic [EXP_W:0]     exp_inc;
  logic [FRAC_W-1:0]  frac_n;
  logic               sat;

  always_comb begin
    exp_inc = {1'b0, exp_q} + {{EXP_W{1'b0}}, sum_q[MANT_W]};
    frac_n  = sum_q[MANT_W] ? sum_q[MANT_W-1:1] : sum_q[FRAC_W-1:0];
    sat     = (exp_inc >= {1'b0, EXP_INF});
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept && !reject) state_d = ALIGN;
      ALIGN:   state_d = ADD;
      ADD:     state_d = NORM;
      NORM:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (clr) state_d = IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc       <= ACC_INIT;
      acc_valid <= 1'b0;
      err       <= 1'b0;
      ovf       <= 1'b0;
      op_q      <= '0;
      mode_q    <= MODE_KEEP;
      exp_q     <= '0;
      ma_q      <= '0;
      mb_q      <= '0;
      sum_q     <= '0;
    end else begin
      acc_valid <= 1'b0;
      err       <= 1'b0;
      if (clr) begin
        acc <= ACC_INIT;
        ovf <= 1'b0;
      end else begin
        case (state_q)
          IDLE: if (accept) begin
            if (reject) err  <= 1'b1;
            else        op_q <= in_data;
          end
          ALIGN: begin
            mode_q <= mode_d;
            exp_q  <= big_exp;
            ma_q   <= big_mant;
            mb_q   <= small_sh;
          end
          ADD: sum_q <= {1'b0, ma_q} + {1'b0, mb_q};
          NORM: begin
            acc_valid <= 1'b1;
            case (mode_q)
              MODE_COPY: acc <= op_q;
              MODE_ADD: begin
                if (sat) begin
                  acc <= POS_INF;
                  ovf <= 1'b1;
                end else begin
                  acc <= {1'b0, exp_inc[EXP_W-1:0], frac_n};
                end
              end
              default: ;
            endcase
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_float_accumulator.sv
// Directed checks of float_accumulator: latency, handshake, sums, saturation, clr/rst.
module tb_float_accumulator;
  logic        clk = 1'b0;
  logic        rst, clr, in_valid, in_ready;
  logic [31:0] in_data, acc;
  logic        acc_valid, err, ovf;
  int          n_chk = 0;
  int          n_pass = 0;

  always #5 clk = ~clk;

  float_accumulator #(.ACC_INIT(32'h0000_0000)) dut (
    .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .acc(acc), .acc_valid(acc_valid), .err(err), .ovf(ovf)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Present an operand and let it be taken on the next rising edge.
  task automatic drive(input logic [31:0] d);
    in_valid = 1'b1;
    in_data  = d;
    #1;
    chk("ready_at_accept", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // From the cycle after accept: 3 busy cycles, then a single-cycle acc_valid.
  task automatic finish_op(input logic [31:0] exp_acc, input string tag);
    for (int i = 0; i < 3; i++) begin
      chk({tag, "_busy"}, 32'(in_ready), 32'd0);
      chk({tag, "_av_early"}, 32'(acc_valid), 32'd0);
      tick();
    end
    chk({tag, "_av"}, 32'(acc_valid), 32'd1);
    chk({tag, "_ready_after"}, 32'(in_ready), 32'd1);
    chk({tag, "_acc"}, acc, exp_acc);
    tick();
    chk({tag, "_av_width"}, 32'(acc_valid), 32'd0);
  endtask

  task automatic add_op(input logic [31:0] d, input logic [31:0] exp_acc, input string tag);
    drive(d);
    finish_op(exp_acc, tag);
  endtask

  task automatic err_op(input logic [31:0] d, input logic [31:0] exp_acc, input string tag);
    drive(d);
    chk({tag, "_err"}, 32'(err), 32'd1);
    chk({tag, "_ready"}, 32'(in_ready), 32'd1);
    tick();
    chk({tag, "_err_width"}, 32'(err), 32'd0);
    for (int i = 0; i < 4; i++) begin
      chk({tag, "_no_av"}, 32'(acc_valid), 32'd0);
      tick();
    end
    chk({tag, "_acc"}, acc, exp_acc);
  endtask

  task automatic do_clr;
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("clr_acc", acc, 32'h0);
    chk("clr_ovf", 32'(ovf), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; clr = 1'b0; in_valid = 1'b0; in_data = '0;
    #1;
    chk("rst_acc", acc, 32'h0);
    chk("rst_ready", 32'(in_ready), 32'd0);
    chk("rst_av", 32'(acc_valid), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1 chk("post_rst_ready", 32'(in_ready), 32'd1);

    // 1, 2, 2, 3, 4 -> 1, 3, 5, 8, 12
    add_op(32'h3F80_0000, 32'h3F80_0000, "s1");
    add_op(32'h4000_0000, 32'h4040_0000, "s2");
    add_op(32'h4000_0000, 32'h40A0_0000, "s3");
    add_op(32'h4040_0000, 32'h4100_0000, "s4");
    add_op(32'h4080_0000, 32'h4140_0000, "s5");

    // Rejected operands and a zero operand with uniform latency
    err_op(32'hBF80_0000, 32'h4140_0000, "neg");
    err_op(32'h7FC0_0000, 32'h4140_0000, "nan");
    err_op(32'h8000_0000, 32'h4140_0000, "negz");
    add_op(32'h0000_0000, 32'h4140_0000, "zero");
    add_op(32'h0000_0001, 32'h4140_0000, "subn");

    // Exponent difference of 24 contributes nothing
    do_clr();
    add_op(32'h4B80_0000, 32'h4B80_0000, "big");
    add_op(32'h3F80_0000, 32'h4B80_0000, "diff24");

    // Saturation to +Inf, sticky ovf
    do_clr();
    add_op(32'h7F7F_FFFF, 32'h7F7F_FFFF, "max");
    chk("max_ovf", 32'(ovf), 32'd0);
    add_op(32'h7F7F_FFFF, 32'h7F80_0000, "sat");
    chk("sat_ovf", 32'(ovf), 32'd1);
    add_op(32'h3F80_0000, 32'h7F80_0000, "inf_keep");
    chk("inf_keep_ovf", 32'(ovf), 32'd1);

    // clr during ALIGN with in_valid high: operand dropped, new one not taken
    drive(32'h3F80_0000);
    clr = 1'b1; in_valid = 1'b1; in_data = 32'h4000_0000;
    #1 chk("clr_align_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    chk("clr_align_acc", acc, 32'h0);
    chk("clr_align_ovf", 32'(ovf), 32'd0);
    chk("clr_align_av", 32'(acc_valid), 32'd0);
    clr = 1'b0;
    add_op(32'h4000_0000, 32'h4000_0000, "after_clr");

    // Reset pulse while in ADD
    drive(32'h3F80_0000);
    tick();
    rst = 1'b1;
    #1;
    chk("rst_add_acc", acc, 32'h0);
    chk("rst_add_av", 32'(acc_valid), 32'd0);
    chk("rst_add_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_rel_ready", 32'(in_ready), 32'd1);
    chk("rst_rel_acc", acc, 32'h0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("rst_rel_no_av", 32'(acc_valid), 32'd0);
    end
    add_op(32'h4080_0000, 32'h4080_0000, "post_rst");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
